// File: rtl/pspin_cmd_sched_pkg.sv
// pspin_cmd_sched_pkg: shared command/response types and scheduler constants.
package pspin_cmd_sched_pkg;
   localparam int NUM_CLUSTERS = 4;
   localparam int NUM_CMD_INTERFACES = 3;
   localparam int MAX_INFLIGHT_DEF = 8;
   typedef logic [$clog2(MAX_INFLIGHT_DEF+1)-1:0] inflight_t;
   typedef struct packed {
      logic [7:0] cluster_id;
      logic [7:0] cmd_idx;
   } pspin_cmd_id_t;
   typedef struct packed {
      pspin_cmd_id_t cmd_id;
      logic [1:0]    intf_id;
      logic [15:0]   data;
   } pspin_cmd_t;
   typedef struct packed {
      pspin_cmd_id_t cmd_id;
      logic [15:0]   status;
   } pspin_cmd_resp_t;
   function automatic int ptr_w(input int n);
      return n > 1 ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/pspin_cmd_sched_picker.sv
// pspin_rr_picker: round-robin pick of one request starting at ptr.
module pspin_rr_picker import pspin_cmd_sched_pkg::*; #(
   parameter int N = 4,
   localparam int PW = ptr_w(N)
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [PW-1:0] sel,
   output logic          valid
);
   always_comb begin
      gnt = '0;
      sel = '0;
      valid = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (!valid && req[(int'(ptr) + k) % N]) begin
            gnt[(int'(ptr) + k) % N] = 1'b1;
            sel = PW'((int'(ptr) + k) % N);
            valid = 1'b1;
         end
      end
   end
endmodule

// File: rtl/pspin_cmd_sched.sv
// pspin_cmd_sched: routes cluster commands to interfaces and completions back,
// with per-interface inflight caps and one grant per direction per cycle.
module pspin_cmd_sched import pspin_cmd_sched_pkg::*; #(
   parameter int NUM_REQ = NUM_CLUSTERS,
   parameter int NUM_INTF = NUM_CMD_INTERFACES,
   parameter int MAX_INFLIGHT = MAX_INFLIGHT_DEF,
   localparam int CW = $clog2(MAX_INFLIGHT + 1),
   localparam int QW = ptr_w(NUM_REQ),
   localparam int IW = ptr_w(NUM_INTF)
) (
   input  logic                               clk_i,
   input  logic                               rst_i,
   input  logic [NUM_REQ-1:0]                 req_valid_i,
   output logic [NUM_REQ-1:0]                 req_ready_o,
   input  pspin_cmd_t [NUM_REQ-1:0]           req_cmd_i,
   output logic [NUM_INTF-1:0]                intf_valid_o,
   input  logic [NUM_INTF-1:0]                intf_ready_i,
   output pspin_cmd_t [NUM_INTF-1:0]          intf_cmd_o,
   input  logic [NUM_INTF-1:0]                intf_resp_valid_i,
   output logic [NUM_INTF-1:0]                intf_resp_ready_o,
   input  pspin_cmd_resp_t [NUM_INTF-1:0]     intf_resp_i,
   output logic [NUM_REQ-1:0]                 resp_valid_o,
   input  logic [NUM_REQ-1:0]                 resp_ready_i,
   output pspin_cmd_resp_t [NUM_REQ-1:0]      resp_o,
   output logic [NUM_INTF-1:0][CW-1:0]        inflight_o,
   output logic                               err_illegal_intf_o,
   output logic                               err_spurious_resp_o
);
   pspin_cmd_t [NUM_INTF-1:0]       slot_cmd;
   logic [NUM_INTF-1:0]             slot_v;
   pspin_cmd_resp_t [NUM_REQ-1:0]   rslot;
   logic [NUM_REQ-1:0]              rslot_v;
   logic [NUM_INTF-1:0][CW-1:0]     cnt;
   logic [QW-1:0]                   rq_ptr, csel;
   logic [IW-1:0]                   rs_ptr, rsel;
   logic [NUM_REQ-1:0]              creq, cgnt, rwr;
   logic [NUM_INTF-1:0]             elig, rreq, rgnt, inc, dec;
   logic                            cval, rval, accept, rs_acc, illegal, resp_bad;
   pspin_cmd_t                      cmd_g;
   pspin_cmd_resp_t                 resp_g;

   pspin_rr_picker #(.N(NUM_REQ)) u_cmd_pick (
      .req(creq), .ptr(rq_ptr), .gnt(cgnt), .sel(csel), .valid(cval));
   pspin_rr_picker #(.N(NUM_INTF)) u_resp_pick (
      .req(rreq), .ptr(rs_ptr), .gnt(rgnt), .sel(rsel), .valid(rval));

   // Handshake outputs are forced low in reset so nothing completes then.
   assign accept = cval && !rst_i;
   assign rs_acc = rval && !rst_i;
   assign req_ready_o = accept ? cgnt : '0;
   assign intf_resp_ready_o = rs_acc ? rgnt : '0;
   assign intf_valid_o = rst_i ? '0 : slot_v;
   assign intf_cmd_o = slot_cmd;
   assign resp_valid_o = rst_i ? '0 : rslot_v;
   assign resp_o = rslot;
   assign inflight_o = rst_i ? '0 : cnt;
   assign cmd_g = req_cmd_i[csel];
   assign resp_g = intf_resp_i[rsel];

   always_comb begin
      elig = '0;
      creq = '0;
      rreq = '0;
      inc = '0;
      dec = '0;
      rwr = '0;
      for (int i = 0; i < NUM_INTF; i++) begin
         elig[i] = (!slot_v[i] || intf_ready_i[i]) && cnt[i] < CW'(MAX_INFLIGHT);
         inc[i] = accept && int'(cmd_g.intf_id) == i;
         dec[i] = intf_resp_ready_o[i];
      end
      // Illegal targets are always eligible so they can be drained and flagged.
      for (int r = 0; r < NUM_REQ; r++) begin
         creq[r] = req_valid_i[r] && int'(req_cmd_i[r].intf_id) >= NUM_INTF;
         for (int i = 0; i < NUM_INTF; i++)
            if (int'(req_cmd_i[r].intf_id) == i) creq[r] = req_valid_i[r] && elig[i];
         rwr[r] = rs_acc && int'(resp_g.cmd_id.cluster_id) == r;
      end
      for (int i = 0; i < NUM_INTF; i++) begin
         rreq[i] = intf_resp_valid_i[i] && int'(intf_resp_i[i].cmd_id.cluster_id) >= NUM_REQ;
         for (int r = 0; r < NUM_REQ; r++)
            if (int'(intf_resp_i[i].cmd_id.cluster_id) == r)
               rreq[i] = intf_resp_valid_i[i] && (!rslot_v[r] || resp_ready_i[r]);
      end
      illegal = accept && int'(cmd_g.intf_id) >= NUM_INTF;
      resp_bad = rs_acc && (int'(resp_g.cmd_id.cluster_id) >= NUM_REQ || cnt[rsel] == '0);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         slot_v <= '0;
         slot_cmd <= '0;
         rslot_v <= '0;
         rslot <= '0;
         cnt <= '0;
         rq_ptr <= '0;
         rs_ptr <= '0;
         err_illegal_intf_o <= 1'b0;
         err_spurious_resp_o <= 1'b0;
      end else begin
         if (accept) rq_ptr <= (int'(csel) == NUM_REQ - 1) ? '0 : csel + QW'(1);
         if (rs_acc) rs_ptr <= (int'(rsel) == NUM_INTF - 1) ? '0 : rsel + IW'(1);
         err_illegal_intf_o <= err_illegal_intf_o | illegal;
         err_spurious_resp_o <= err_spurious_resp_o | resp_bad;
         for (int i = 0; i < NUM_INTF; i++) begin
            if (intf_ready_i[i]) slot_v[i] <= 1'b0;
            if (inc[i]) begin
               slot_v[i] <= 1'b1;
               slot_cmd[i] <= cmd_g;
            end
            if (inc[i] && !dec[i]) cnt[i] <= cnt[i] + CW'(1);
            else if (dec[i] && !inc[i] && cnt[i] != '0) cnt[i] <= cnt[i] - CW'(1);
         end
         for (int r = 0; r < NUM_REQ; r++) begin
            if (resp_ready_i[r]) rslot_v[r] <= 1'b0;
            if (rwr[r]) begin
               rslot_v[r] <= 1'b1;
               rslot[r] <= resp_g;
            end
         end
      end
   end
endmodule
